parking_occupancy: RTL

PARKING_OCCUPANCY -- requirements
Module: parking_occupancy

---
 rtl/parking_occupancy.sv | 103 ++++++++++
 1 files changed

// File: rtl/parking_occupancy.sv
// parking_occupancy: per-gate two-sensor entry/exit FSMs feeding a saturating occupancy counter; PARK_DEBOUNCE_EN adds sensor debounce filters
module parking_occupancy #(
    parameter int N_GATES = 2,
    parameter int CAPACITY = 100,
    parameter int CNT_W = 7,
    parameter int DEB_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_GATES-1:0] sensor1,
    input  logic [N_GATES-1:0] sensor2,
    output logic [N_GATES-1:0] incr,
    output logic [N_GATES-1:0] decr,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty,
    output logic               sat_err
);
    typedef enum logic [1:0] {IDLE, FIRST, BOTH, LAST} state_t;
    localparam int W = CNT_W + 4;
    logic [N_GATES-1:0] s1, s2;
`ifdef PARK_DEBOUNCE_EN
    logic [2*N_GATES-1:0] raw, filt;
    assign raw = {sensor2, sensor1};
    assign {s2, s1} = filt;
    for (genvar b = 0; b < 2*N_GATES; b++) begin : g_deb
        logic [7:0] cnt;
        logic f;
        assign filt[b] = f;
        always_ff @(posedge clk)
            if (rst) begin
                f <= 1'b0;
                cnt <= '0;
            end else if (raw[b] == f) begin
                cnt <= '0;
            end else if (cnt == 8'(DEB_CYCLES - 1)) begin
                f <= raw[b];
                cnt <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
    end
`else
    assign s1 = sensor1;
    assign s2 = sensor2;
`endif
    for (genvar g = 0; g < N_GATES; g++) begin : g_gate
        state_t st, nx;
        logic dir, dir_nx, done, far, inc_q, dec_q;
        logic [1:0] s;
        // dir: 0 = entering (outer sensor first), 1 = leaving
        assign s = {s1[g], s2[g]};
        assign far = dir ? s == 2'b10 : s == 2'b01;
        always_ff @(posedge clk)
            if (rst) begin
                st <= IDLE;
                dir <= 1'b0;
                inc_q <= 1'b0;
                dec_q <= 1'b0;
            end else begin
                st <= nx;
                dir <= dir_nx;
                inc_q <= done && !dir;
                dec_q <= done && dir;
            end
        always_comb begin
            nx = st;
            dir_nx = dir;
            case (st)
                IDLE: begin
                    nx = s == 2'b10 || s == 2'b01 ? FIRST : IDLE;
                    dir_nx = s == 2'b01 ? 1'b1 : s == 2'b10 ? 1'b0 : dir;
                end
                FIRST: nx = s == 2'b11 ? BOTH : s == 2'b00 ? IDLE : FIRST;
                BOTH: nx = s == 2'b00 ? IDLE : s == 2'b11 ? BOTH : far ? LAST : FIRST;
                LAST: nx = s == 2'b00 ? IDLE : s == 2'b11 ? BOTH : LAST;
                default: nx = IDLE;
            endcase
        end
        always_comb done = st == LAST && s == 2'b00;
        assign incr[g] = inc_q;
        assign decr[g] = dec_q;
    end
    logic signed [W-1:0] sum;
    logic lo, hi;
    // all gates are summed before clipping so opposing moves cancel
    always_comb begin
        sum = $signed(W'(count));
        for (int i = 0; i < N_GATES; i++) sum = sum + $signed(W'(incr[i])) - $signed(W'(decr[i]));
        lo = sum[W-1];
        hi = !lo && sum > $signed(W'(CAPACITY));
    end
    always_ff @(posedge clk)
        if (rst) begin
            count <= '0;
            sat_err <= 1'b0;
        end else begin
            count <= lo ? '0 : hi ? CNT_W'(CAPACITY) : sum[CNT_W-1:0];
            sat_err <= sat_err | lo | hi;
        end
    assign full = count == CNT_W'(CAPACITY);
    assign empty = count == '0;
endmodule
